// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared states and widths for the serial subtractor driver and its bench
package serial_sub_pkg;
   localparam int DEF_W = 4;
   localparam int PHASE_LEN = DEF_W;
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/four_bit_serial_sub_driver_sipo.sv
// sipo_shift_reg: right-shifting serial-in/parallel-out register, newest bit enters at the MSB
module sipo_shift_reg #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_en,
   input  logic         i_bit,
   output logic [W-1:0] o_data
);
   always_ff @(posedge clk)
      if (!rstn) o_data <= '0;
      else if (i_en) o_data <= W'({i_bit, o_data} >> 1);
endmodule

// File: rtl/four_bit_serial_sub_driver.sv
// four_bit_serial_sub_driver: parallel operands to serial SI/SE for the subtractor, serial difference back to parallel
module four_bit_serial_sub_driver
   import serial_sub_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         ready,
   output logic         sub_rstn,
   output logic         SI,
   output logic         SE,
   input  logic         diff_in,
   input  logic         borrow_in,
   output logic [W-1:0] diff_out,
   output logic         borrow_out,
   output logic         done
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   state_t r_state, w_next;
   logic [CW-1:0] r_count;
   logic [W-1:0] r_a, r_b, w_diff_sr;
   logic w_last, w_run;
   assign w_last = r_count == CW'(W - 1);
   assign w_run = r_state == RUN;
   always_ff @(posedge clk)
      r_state <= !rstn ? IDLE : w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? CLEAR : IDLE;
         CLEAR:   w_next = LOAD;
         LOAD:    w_next = w_last ? RUN : LOAD;
         RUN:     w_next = w_last ? DONE : RUN;
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      ready = r_state == IDLE;
      SE = r_state == LOAD || w_run;
      SI = r_state == LOAD ? r_b[r_count] : w_run ? r_a[r_count] : 1'b0;
   end
   // global reset also clears the subtractor
   assign sub_rstn = rstn && r_state != CLEAR;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_count <= '0;
         r_a <= '0;
         r_b <= '0;
         done <= 1'b0;
         diff_out <= '0;
         borrow_out <= 1'b0;
      end else begin
         r_count <= SE && !w_last ? r_count + 1'b1 : '0;
         done <= r_state == DONE;
         if (ready && start) begin
            r_a <= a;
            r_b <= b;
         end
         if (r_state == DONE) begin
            diff_out <= w_diff_sr;
            borrow_out <= borrow_in;
         end
      end
   end
   sipo_shift_reg #(.W(W)) u_diff_sr (
      .clk    (clk),
      .rstn   (rstn),
      .i_en   (w_run),
      .i_bit  (diff_in),
      .o_data (w_diff_sr)
   );
endmodule

// File: tb/tb_four_bit_serial_sub_driver.sv
// tb_four_bit_serial_sub_driver: random and directed operations against a behavioural serial subtractor and a-b arithmetic
module tb_four_bit_serial_sub_driver;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rstn, start, ready, sub_rstn, SI, SE, diff_in, borrow_in, borrow_out, done;
   logic [W-1:0] a, b, diff_out;
   int n_tests = 0, n_fail = 0;
   int se_cnt, clr_cnt, rdy_cnt;
   logic [2*W-1:0] si_seq;
   longint t1;
   logic m_bor;
   logic m_bits [2*W];
   int m_n;
   always #5 clk = ~clk;
   four_bit_serial_sub_driver #(.W(W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .a          (a),
      .b          (b),
      .ready      (ready),
      .sub_rstn   (sub_rstn),
      .SI         (SI),
      .SE         (SE),
      .diff_in    (diff_in),
      .borrow_in  (borrow_in),
      .diff_out   (diff_out),
      .borrow_out (borrow_out),
      .done       (done)
   );
   // subtractor: first W shifted bits are the subtrahend, next W the minuend, ripple borrow in a flop
   always @(posedge clk) begin
      if (!sub_rstn) begin
         m_bor <= 1'b0;
         m_n <= 0;
      end else if (SE) begin
         if (m_n < 2*W) m_bits[m_n] <= SI;
         if (m_n >= W && m_n < 2*W)
            m_bor <= (!SI && m_bits[m_n-W]) || (!(SI ^ m_bits[m_n-W]) && m_bor);
         m_n <= m_n + 1;
      end
   end
   assign diff_in = (m_n >= W && m_n < 2*W) ? SI ^ m_bits[m_n-W] ^ m_bor : 1'b0;
   assign borrow_in = m_bor;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit keep,
                     input logic [W-1:0] na, input logic [W-1:0] nb, input bit noise);
      int k;
      logic [W:0] ref_v;
      k = 0;
      start = 1'b1;
      a = ia;
      b = ib;
      se_cnt = 0;
      clr_cnt = 0;
      rdy_cnt = 0;
      si_seq = '0;
      do begin
         @(negedge clk);
         k++;
         if (SE) begin
            if (se_cnt < 2*W) si_seq[se_cnt] = SI;
            se_cnt++;
         end
         if (!sub_rstn) clr_cnt++;
         if (ready && !done) rdy_cnt++;
         if (k == 1) begin
            chk("clear_after_accept", sub_rstn, 0);
            start = keep;
            a = na;
            b = nb;
         end else if (noise) begin
            start = (k >= 3 && k <= 9) ? k[0] : 1'b0;
            a = W'($urandom);
            b = W'($urandom);
         end
      end while (!done && k < 40);
      ref_v = {1'b0, ia} - {1'b0, ib};
      chk("done_seen", done, 1);
      chk("latency", k - 1, 2*W + 2);
      chk("se_cycles", se_cnt, 2*W);
      chk("clear_cycles", clr_cnt, 1);
      chk("ready_low", rdy_cnt, 0);
      chk("si_seq", si_seq, {ia, ib});
      chk("diff", diff_out, ref_v[W-1:0]);
      chk("borrow", borrow_out, ref_v[W]);
      chk("ready_in_done", ready, 1);
   endtask
   initial begin
      rstn = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      @(negedge clk);
      chk("rst_sub_rstn", sub_rstn, 0);
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_se", SE, 0);
      chk("rst_si", SI, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff_out, 0);
      chk("rst_borrow", borrow_out, 0);
      rstn = 1'b1;
      @(negedge clk);
      op(4'd9, 4'd3, 0, W'($urandom), W'($urandom), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      op(4'd3, 4'd5, 0, W'($urandom), W'($urandom), 0);
      op(4'd0, 4'd0, 0, W'($urandom), W'($urandom), 0);
      op(4'd7, 4'd2, 0, W'($urandom), W'($urandom), 1);
      repeat (3) @(negedge clk);
      chk("noise_no_done", done, 0);
      chk("noise_idle", ready, 1);
      chk("noise_se", SE, 0);
      op(4'd8, 4'd1, 1, 4'd1, 4'd8, 0);
      t1 = $time;
      op(4'd1, 4'd8, 0, W'($urandom), W'($urandom), 0);
      chk("b2b_gap", 32'(($time - t1) / 10), 11);
      for (int i = 0; i < 8; i++) op(W'($urandom), W'($urandom), 0, W'($urandom), W'($urandom), 0);
      op(4'd12, 4'd5, 0, W'($urandom), W'($urandom), 0);
      start = 1'b1;
      a = 4'd13;
      b = 4'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_run_se", SE, 1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_sub_rstn", sub_rstn, 0);
      @(negedge clk);
      rstn = 1'b1;
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_se", SE, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_diff", diff_out, 0);
      chk("mid_rst_borrow", borrow_out, 0);
      op(4'd13, 4'd6, 0, W'($urandom), W'($urandom), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
